// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external modmul.
// Optional MODEXP_SKIP_LEADING_EN: skips the 1*1 squarings before the first multiply.
module modexp_ctrl #(
  parameter int W  = 2048,
  parameter int EW = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [W-1:0]  modulus,
  output logic [W-1:0]  result,
  output logic          mm_start,
  input  logic          mm_ready,
  output logic [W-1:0]  mm_a,
  output logic [W-1:0]  mm_b,
  output logic [W-1:0]  mm_n,
  input  logic [W-1:0]  mm_p
);

  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    FINISH
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  base_reg, base_next;
  logic [EW-1:0] exp_reg, exp_next;
  logic [W-1:0]  mod_reg, mod_next;
  logic [W-1:0]  r_reg, r_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [W-1:0]  result_reg, result_next;
  logic [W-1:0]  mm_a_reg, mm_a_next;
  logic [W-1:0]  mm_b_reg, mm_b_next;
`ifdef MODEXP_SKIP_LEADING_EN
  logic          r_is_one_reg, r_is_one_next;
`endif

  logic last_bit;
  logic cur_bit;

  assign last_bit = (idx_reg == '0);
  assign cur_bit  = exp_reg[idx_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      exp_reg      <= '0;
      mod_reg      <= '0;
      r_reg        <= '0;
      idx_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      mm_a_reg     <= '0;
      mm_b_reg     <= '0;
`ifdef MODEXP_SKIP_LEADING_EN
      r_is_one_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      exp_reg      <= exp_next;
      mod_reg      <= mod_next;
      r_reg        <= r_next;
      idx_reg      <= idx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      mm_a_reg     <= mm_a_next;
      mm_b_reg     <= mm_b_next;
`ifdef MODEXP_SKIP_LEADING_EN
      r_is_one_reg <= r_is_one_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    exp_next      = exp_reg;
    mod_next      = mod_reg;
    r_next        = r_reg;
    idx_next      = idx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    result_next   = result_reg;
    mm_a_next     = mm_a_reg;
    mm_b_next     = mm_b_reg;
    mm_start      = 1'b0;
`ifdef MODEXP_SKIP_LEADING_EN
    r_is_one_next = r_is_one_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next     = base;
          exp_next      = exp;
          mod_next      = modulus;
          r_next        = W'(1);
          idx_next      = IW'(EW - 1);
          busy_next     = 1'b1;
`ifdef MODEXP_SKIP_LEADING_EN
          r_is_one_next = 1'b1;
`endif
          state_next    = SQ_ISSUE;
        end
      end

      SQ_ISSUE: begin
`ifdef MODEXP_SKIP_LEADING_EN
        // Squaring 1 is a no-op: walk the leading zero bits one per cycle.
        if (r_is_one_reg) begin
          if (cur_bit) begin
            state_next = MUL_ISSUE;
          end else if (last_bit) begin
            state_next = FINISH;
          end else begin
            idx_next = idx_reg - IW'(1);
          end
        end else if (mm_ready) begin
          mm_start   = 1'b1;
          state_next = SQ_WAIT;
        end
`else
        if (mm_ready) begin
          mm_start   = 1'b1;
          state_next = SQ_WAIT;
        end
`endif
      end

      SQ_WAIT: begin
        if (mm_ready) begin
          r_next = mm_p;
          if (cur_bit) begin
            state_next = MUL_ISSUE;
          end else if (last_bit) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx_reg - IW'(1);
            state_next = SQ_ISSUE;
          end
        end
      end

      MUL_ISSUE: begin
        if (mm_ready) begin
          mm_start   = 1'b1;
          state_next = MUL_WAIT;
        end
      end

      MUL_WAIT: begin
        if (mm_ready) begin
          r_next = mm_p;
`ifdef MODEXP_SKIP_LEADING_EN
          r_is_one_next = 1'b0;
`endif
          if (last_bit) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx_reg - IW'(1);
            state_next = SQ_ISSUE;
          end
        end
      end

      FINISH: begin
        result_next = r_reg;
        done_next   = 1'b1;
        busy_next   = 1'b0;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Operands only change on entry to an ISSUE state, so modmul sees them
    // stable for the whole multiply and the capture cycle.
    if (state_next == SQ_ISSUE) begin
      mm_a_next = r_next;
      mm_b_next = r_next;
    end else if (state_next == MUL_ISSUE) begin
      mm_a_next = r_next;
      mm_b_next = base_next;
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign mm_a   = mm_a_reg;
  assign mm_b   = mm_b_reg;
  assign mm_n   = mod_reg;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural W-cycle modmul model.
// Pulse-count expectations follow MODEXP_SKIP_LEADING_EN when it is defined.
module tb_modexp_ctrl;

  localparam int W  = 8;
  localparam int EW = 8;
`ifdef MODEXP_SKIP_LEADING_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exp = '0;
  logic [W-1:0]  modulus = '0;
  logic [W-1:0]  result;
  logic          mm_start;
  logic          mm_ready;
  logic [W-1:0]  mm_a, mm_b, mm_n;
  logic [W-1:0]  mm_p;

  always #5 clk = ~clk;

  modexp_ctrl #(.W(W), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .base(base), .exp(exp), .modulus(modulus), .result(result),
    .mm_start(mm_start), .mm_ready(mm_ready), .mm_a(mm_a), .mm_b(mm_b),
    .mm_n(mm_n), .mm_p(mm_p)
  );

  // Behavioural modmul: busy for W cycles after an accepted start, reads its
  // operands on every busy cycle and flags any change.
  logic         mb_reg;
  logic [7:0]   cnt_reg;
  logic [W-1:0] la_reg, lb_reg, ln_reg;
  logic         stable_reg;
  logic         fin_reg;

  assign mm_ready = ~mb_reg;

  always @(posedge clk) begin
    if (rst) begin
      mb_reg     <= 1'b0;
      cnt_reg    <= '0;
      fin_reg    <= 1'b0;
      stable_reg <= 1'b1;
      mm_p       <= '0;
    end else if (!mb_reg && mm_start) begin
      mb_reg     <= 1'b1;
      cnt_reg    <= 8'(W - 1);
      la_reg     <= mm_a;
      lb_reg     <= mm_b;
      ln_reg     <= mm_n;
      stable_reg <= 1'b1;
      fin_reg    <= 1'b0;
    end else if (mb_reg) begin
      if (mm_a != la_reg || mm_b != lb_reg || mm_n != ln_reg) stable_reg <= 1'b0;
      if (cnt_reg == 0) begin
        mb_reg  <= 1'b0;
        fin_reg <= 1'b1;
        mm_p    <= (mm_n == 0) ? '0 : W'((16'(mm_a) * 16'(mm_b)) % 16'(mm_n));
      end else begin
        cnt_reg <= cnt_reg - 8'd1;
      end
    end else begin
      fin_reg <= 1'b0;
    end
  end

  typedef struct {
    logic [W-1:0] res;
    int           pulses;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   end_req = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin
    bit   prev_start = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, rst_pend = 1'b0;
    int   pulse_cnt = 0, busy_run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rst_pend = 1'b1;
        exp_q.delete();
        pulse_cnt = 0;
        busy_run = 0;
        prev_start = 1'b0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (rst_pend) begin
          rst_pend = 1'b0;
          check(!busy && !done && !mm_start && result == '0, "reset_state",
                {busy, done, mm_start, result}, 0);
        end
        if (busy && !prev_busy) pulse_cnt = 0;
        if (mm_start) begin
          pulse_cnt++;
          check(!prev_start && mm_ready, "mm_start_legal", {prev_start, mm_ready}, 1);
        end
        if (fin_reg)
          check(stable_reg && mm_a == la_reg && mm_b == lb_reg && mm_n == ln_reg,
                "operand_stable", {mm_a, mm_b}, {la_reg, lb_reg});
        if (prev_done) check(!busy, "busy_after_done", busy, 0);
        if (done) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_done", result, 0);
          end else begin
            e = exp_q.pop_front();
            check(result == e.res, {e.name, "_result"}, result, e.res);
            check(pulse_cnt == e.pulses, {e.name, "_mm_starts"}, pulse_cnt, e.pulses);
            $display("txn %s: result=%0d (exp %0d) mm_start=%0d (exp %0d)",
                     e.name, result, e.res, pulse_cnt, e.pulses);
          end
        end
        busy_run = busy ? busy_run + 1 : 0;
        if (busy_run == 2000) check(1'b0, "busy_timeout", busy_run, 0);
        prev_start = mm_start;
        prev_busy = busy;
        prev_done = done;
      end
      if (end_req) begin
        check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
      end
    end
  end

  task automatic issue(input string name, input logic [W-1:0] b, input logic [EW-1:0] e,
                       input logic [W-1:0] m, input logic [W-1:0] res,
                       input int p_full, input int p_skip);
    exp_t x;
    x.res = res;
    x.pulses = SKIP ? p_skip : p_full;
    x.name = name;
    exp_q.push_back(x);
    start = 1'b1; base = b; exp = e; modulus = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    issue("t1_3p5m7", 8'd3, 8'd5, 8'd7, 8'd5, 10, 4);          wait_done();
    issue("t2_2pffm13", 8'd2, 8'hFF, 8'd13, 8'd8, 16, 15);     wait_done();
    issue("t3_exp0", 8'd4, 8'd0, 8'd11, 8'd1, 8, 0);           wait_done();
    issue("t4_base0", 8'd0, 8'd3, 8'd5, 8'd0, 10, 3);          wait_done();
    issue("t5_5p3m11", 8'd5, 8'd3, 8'd11, 8'd4, 10, 3);        wait_done();

    // Second start mid-run must be ignored.
    issue("t6_restart", 8'd3, 8'd5, 8'd7, 8'd5, 10, 4);
    repeat (8) begin @(posedge clk); #1; end
    start = 1'b1; base = 8'd2; exp = 8'hFF; modulus = 8'd13;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Reset while a multiply is in flight (R=1, base=3 gives mm_a != mm_b).
    issue("t7_aborted", 8'd3, 8'd5, 8'd7, 8'd5, 10, 4);
    for (int i = 0; i < 2000; i++) begin
      if (busy && !mm_ready && mm_a != mm_b) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    issue("t8_after_rst", 8'd3, 8'd5, 8'd7, 8'd5, 10, 4);      wait_done();

    end_req = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
Sequencer that computes base^exp mod modulus by driving one external modmul instance through left-to-right binary square-and-multiply. Sits between the RSA host/control logic and the modular multiplier. Owns operand muxing, the modmul start/ready handshake and the running result register; does no arithmetic itself.

Parameters:
W, 2048, operand width (base, modulus, result, multiplier operands); must equal the connected modmul's W.
EW, 2048, exponent width in bits.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
start  input  1  host request; sampled only in IDLE.
busy  output  1  high while an exponentiation is in progress.
done  output  1  one-cycle pulse when result is valid.
base  input  W  message/base; captured at accepted start; must be < modulus.
exp  input  EW  exponent; captured at accepted start.
modulus  input  W  modulus; captured at accepted start; must be >= 2.
result  output  W  final value; held from done until the next accepted start.
mm_start  output  1  start pulse to modmul.
mm_ready  input  1  modmul ready (high when modmul idle).
mm_a  output  W  modmul operand a.
mm_b  output  W  modmul operand b.
mm_n  output  W  modmul modulus (captured modulus register).
mm_p  input  W  modmul product.

Behaviour:
- Reset: state IDLE; busy=0, done=0, mm_start=0, result=0, R=0, bit index=0, operand registers=0.
- States: IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH.
- IDLE: start=1 -> capture base/exp/modulus, R<=1, idx<=EW-1, busy<=1, go SQ_ISSUE. start=0 -> stay.
- SQ_ISSUE: mm_a=mm_b=R; mm_start=1 only when mm_ready=1, then go SQ_WAIT. mm_ready=0 -> hold, no pulse.
- SQ_WAIT: when mm_ready=1 -> R<=mm_p. If exp[idx]=1 go MUL_ISSUE, else advance.
- MUL_ISSUE/MUL_WAIT: same handshake with mm_a=R, mm_b=base. On capture, advance.
- Advance: idx=0 -> FINISH; otherwise idx<=idx-1, go SQ_ISSUE.
- FINISH: result<=R, done=1 for exactly one cycle, busy<=0, go IDLE.
- mm_start is never high two consecutive cycles. It is only high in an ISSUE state.
- mm_a, mm_b, mm_n are registered and stay stable from the ISSUE cycle through the capturing WAIT cycle, because modmul reads them every busy cycle.
- The first WAIT cycle after issue sees mm_ready=0, since modmul leaves IDLE on the issue edge.
- Per multiplication: 1 ISSUE cycle + W busy cycles + 1 capture cycle = W+2 cycles.
- start while busy=1 is ignored; captured operands do not change.
- rst mid-operation: immediate return to reset values. The shared rst also resets modmul, so no in-flight multiply survives.
- exp=0: result=1.
- Operand constraints (base<modulus, modulus>=2) are the host's responsibility; violating them gives an undefined result but legal sequencing.

Optional Feature:
Macro MODEXP_SKIP_LEADING_EN.
- Defined: a flag r_is_one is set at start and cleared at the first MUL capture. While r_is_one=1, SQ_ISSUE/SQ_WAIT are bypassed (1*1 squaring skipped). exp=0 then completes with zero mm_start pulses.
- Undefined: all EW squarings are performed.
- Result is identical in both builds; only cycle count and mm_start count differ.

Test Plan:
Bench uses W=8, EW=8, modmul connected.
- base=3, exp=5, modulus=7 -> done pulse, result=5. mm_start count: 10 without feature, 4 with it.
- base=2, exp=0xFF, modulus=13 -> result=8. 16 mm_start pulses without feature, 15 with it.
- base=4, exp=0, modulus=11 -> result=1. 8 pulses without feature, 0 with it. busy is low the cycle after done.
- base=0, exp=3, modulus=5 -> result=0. Check mm_a/mm_b stay stable across every WAIT window.
- start pulsed again mid-run with different operands -> ignored; result matches the first operand set; exactly one done.
- rst asserted during a MUL_WAIT -> next cycle busy=0, done=0, mm_start=0, result=0. A following start with base=3, exp=5, modulus=7 gives result=5.
